piano_voice_allocator: RTL and testbench

Maps the eight piano key switches onto a limited pool of tone-generator voices. Each raw switch is synchronised and debounced. Each newly pressed note is assigned to a free voice, which holds the note while the key is down and then runs a fixed release tail before returning to the pool. The block sits between the board switches and the per-voice tone generators, replacing direct switch-to-enable wiring.

---
 rtl/piano_voice_allocator_pkg.sv | 22 ++
 rtl/piano_voice_allocator_if.sv | 28 ++
 rtl/piano_voice_allocator_key_debounce.sv | 44 ++++
 rtl/piano_voice_allocator.sv | 153 +++++++++++++++
 tb/tb_piano_voice_allocator.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/piano_voice_allocator_pkg.sv
// Shared note/voice definitions for the piano voice allocator.
package piano_pkg;

  localparam int unsigned NUM_NOTES = 8;
  localparam int unsigned NOTE_W    = 3;

  localparam logic [NOTE_W-1:0] NOTE_C  = 3'd0;
  localparam logic [NOTE_W-1:0] NOTE_D  = 3'd1;
  localparam logic [NOTE_W-1:0] NOTE_E  = 3'd2;
  localparam logic [NOTE_W-1:0] NOTE_F  = 3'd3;
  localparam logic [NOTE_W-1:0] NOTE_G  = 3'd4;
  localparam logic [NOTE_W-1:0] NOTE_A  = 3'd5;
  localparam logic [NOTE_W-1:0] NOTE_B  = 3'd6;
  localparam logic [NOTE_W-1:0] NOTE_C2 = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } voice_state_t;

endpackage

// File: rtl/piano_voice_allocator_if.sv
// Key-switch inputs and per-voice control outputs of the allocator.
interface piano_voice_allocator_if
  import piano_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4
);

  logic [NUM_NOTES-1:0]         sw;
  logic [NUM_NOTES-1:0]         db_keys;
  logic [NOTE_W*NUM_VOICES-1:0] voice_note;
  logic [NUM_VOICES-1:0]        voice_gate;
  logic [NUM_VOICES-1:0]        voice_busy;
  logic [NUM_VOICES-1:0]        voice_start;
  logic                         starved;

  // Allocator side: consumes switches, drives voice controls.
  modport master (
    input  sw,
    output db_keys, voice_note, voice_gate, voice_busy, voice_start, starved
  );

  // Board/tone-generator side.
  modport slave (
    output sw,
    input  db_keys, voice_note, voice_gate, voice_busy, voice_start, starved
  );

endinterface

// File: rtl/piano_voice_allocator_key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a single key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic db
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous switch into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Toggle the debounced level only after it has differed for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      db  <= ~db;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piano_voice_allocator.sv
// Debounces the eight key switches and assigns pressed notes to a pool of
// voices, each running IDLE -> ACTIVE -> RELEASE -> IDLE.
module piano_voice_allocator
  import piano_pkg::*;
#(
  parameter int unsigned NUM_VOICES      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned RELEASE_CYCLES  = 1000000
) (
  input logic                    clk,
  input logic                    rst_n,
  piano_voice_allocator_if.master bus
);

  localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_LOAD = REL_W'(RELEASE_CYCLES - 1);

  logic [NUM_NOTES-1:0]  db_keys;

  voice_state_t          state_q [NUM_VOICES];
  voice_state_t          state_d [NUM_VOICES];
  logic [NOTE_W-1:0]     note_q  [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d  [NUM_VOICES];
  logic [REL_W-1:0]      rel_q   [NUM_VOICES];
  logic [REL_W-1:0]      rel_d   [NUM_VOICES];

  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NUM_VOICES-1:0] busy_q, busy_d;
  logic [NUM_VOICES-1:0] start_q, start_d;
  logic                  starved_q, starved_d;

  logic [NUM_NOTES-1:0]  held;
  logic [NUM_NOTES-1:0]  unassigned;
  logic                  have_key;
  logic [NOTE_W-1:0]     grant_note;
  logic [NUM_VOICES-1:0] idle_vec;
  logic [NUM_VOICES-1:0] idle_lsb;

  // One synchroniser/debouncer per key.
  for (genvar n = 0; n < NUM_NOTES; n++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .sw   (bus.sw[n]),
      .db   (db_keys[n])
    );
  end

  // Allocation decision and per-voice next state.
  always_comb begin
    held       = '0;
    idle_vec   = '0;
    have_key   = 1'b0;
    grant_note = '0;
    gate_d     = '0;
    busy_d     = '0;
    start_d    = '0;

    // A note is covered while any busy voice holds it, including in its tail.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (state_q[v] != IDLE) held[note_q[v]] = 1'b1;
      idle_vec[v] = (state_q[v] == IDLE);
    end
    unassigned = db_keys & ~held;

    // Lowest unassigned note wins: scan downward so the last hit is the lowest.
    for (int n = NUM_NOTES - 1; n >= 0; n--) begin
      if (unassigned[n]) begin
        have_key   = 1'b1;
        grant_note = NOTE_W'(n);
      end
    end

    // Lowest IDLE voice as a one-hot mask.
    idle_lsb = idle_vec & (~idle_vec + NUM_VOICES'(1));

    for (int v = 0; v < NUM_VOICES; v++) begin
      state_d[v] = state_q[v];
      note_d[v]  = note_q[v];
      rel_d[v]   = rel_q[v];
      case (state_q[v])
        IDLE: begin
          if (have_key && idle_lsb[v]) begin
            state_d[v] = ACTIVE;
            note_d[v]  = grant_note;
            start_d[v] = 1'b1;
          end
        end
        ACTIVE: begin
          if (!db_keys[note_q[v]]) begin
            state_d[v] = RELEASE;
            rel_d[v]   = REL_LOAD;
          end
        end
        RELEASE: begin
          // Retrigger beats expiry when both happen together.
          if (db_keys[note_q[v]]) begin
            state_d[v] = ACTIVE;
            start_d[v] = 1'b1;
          end else if (rel_q[v] == '0) begin
            state_d[v] = IDLE;
          end else begin
            rel_d[v] = rel_q[v] - REL_W'(1);
          end
        end
        default: state_d[v] = IDLE;
      endcase
      gate_d[v] = (state_d[v] == ACTIVE);
      busy_d[v] = (state_d[v] != IDLE);
    end

    starved_d = have_key && (idle_vec == '0);
  end

  // Voice state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= IDLE;
        note_q[v]  <= '0;
        rel_q[v]   <= '0;
      end
      gate_q    <= '0;
      busy_q    <= '0;
      start_q   <= '0;
      starved_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= state_d[v];
        note_q[v]  <= note_d[v];
        rel_q[v]   <= rel_d[v];
      end
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      starved_q <= starved_d;
    end
  end

  // Flatten per-voice notes onto the output bus.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note
    assign bus.voice_note[NOTE_W*v +: NOTE_W] = note_q[v];
  end

  assign bus.db_keys     = db_keys;
  assign bus.voice_gate  = gate_q;
  assign bus.voice_busy  = busy_q;
  assign bus.voice_start = start_q;
  assign bus.starved     = starved_q;

endmodule

// File: tb/tb_piano_voice_allocator.sv
// Directed bench for piano_voice_allocator with short debounce/release windows.
module tb_piano_voice_allocator;

  localparam int unsigned NV  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned REL = 8;

  logic clk;
  logic rst_n;

  int unsigned n_cmp;
  int unsigned n_bad;

  piano_voice_allocator_if #(.NUM_VOICES(NV)) bus ();

  piano_voice_allocator #(
    .NUM_VOICES     (NV),
    .DEBOUNCE_CYCLES(DEB),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] all_out();
    return 64'({bus.db_keys, bus.voice_note, bus.voice_gate,
                bus.voice_busy, bus.voice_start, bus.starved});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] chord_notes [4];
    chord_notes[0] = 3'd0;
    chord_notes[1] = 3'd1;
    chord_notes[2] = 3'd6;
    chord_notes[3] = 3'd7;
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    bus.sw = 8'h00;

    // 1. reset then idle
    cyc(3);
    check_eq("reset_outputs", all_out(), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      check_eq("idle_outputs", all_out(), 64'd0);
    end

    // 2. bounce rejection on key 4
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) bus.sw[4] = ~bus.sw[4];
      cyc(1);
      check_eq("bounce_db", 64'(bus.db_keys), 64'h00);
    end
    bus.sw[4] = 1'b1;
    cyc(5);
    check_eq("deb_before", 64'(bus.db_keys), 64'h00);
    cyc(1);
    check_eq("deb_rise", 64'(bus.db_keys), 64'h10);
    check_eq("deb_gate0", 64'(bus.voice_gate), 64'h0);
    cyc(1);
    check_eq("g4_gate", 64'(bus.voice_gate), 64'h1);
    check_eq("g4_start", 64'(bus.voice_start), 64'h1);
    check_eq("g4_note", 64'(bus.voice_note[2:0]), 64'd4);
    check_eq("g4_busy", 64'(bus.voice_busy), 64'h1);
    cyc(1);
    check_eq("g4_start_end", 64'(bus.voice_start), 64'h0);
    check_eq("g4_gate_hold", 64'(bus.voice_gate), 64'h1);

    // release key 4 and time the tail
    bus.sw = 8'h00;
    cyc(6);
    check_eq("r4_db", 64'(bus.db_keys), 64'h00);
    check_eq("r4_gate_hold", 64'(bus.voice_gate), 64'h1);
    cyc(1);
    check_eq("r4_gate_fall", 64'(bus.voice_gate), 64'h0);
    check_eq("r4_busy", 64'(bus.voice_busy), 64'h1);
    cyc(7);
    check_eq("r4_busy_last", 64'(bus.voice_busy), 64'h1);
    cyc(1);
    check_eq("r4_idle", 64'(bus.voice_busy), 64'h0);
    cyc(2);

    // 3. chord C D B C2
    bus.sw = 8'hC3;
    cyc(6);
    check_eq("chord_db", 64'(bus.db_keys), 64'hC3);
    check_eq("chord_gate0", 64'(bus.voice_gate), 64'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check_eq("chord_gate", 64'(bus.voice_gate), 64'((1 << (i + 1)) - 1));
      check_eq("chord_start", 64'(bus.voice_start), 64'(1 << i));
      check_eq("chord_note", 64'(bus.voice_note[3*i +: 3]), 64'(chord_notes[i]));
      check_eq("chord_starved", 64'(bus.starved), 64'd0);
    end
    cyc(1);
    check_eq("chord_notes_all", 64'(bus.voice_note), 64'hF88);
    check_eq("chord_start_end", 64'(bus.voice_start), 64'h0);
    check_eq("chord_starved_end", 64'(bus.starved), 64'd0);

    // 4. overflow: press E with all voices held
    bus.sw = 8'hC7;
    cyc(6);
    check_eq("ovf_db", 64'(bus.db_keys), 64'hC7);
    check_eq("ovf_starved_pre", 64'(bus.starved), 64'd0);
    cyc(1);
    check_eq("ovf_starved", 64'(bus.starved), 64'd1);
    check_eq("ovf_no_start", 64'(bus.voice_start), 64'h0);
    bus.sw = 8'hC6;
    cyc(6);
    check_eq("ovf_rel_db", 64'(bus.db_keys), 64'hC6);
    check_eq("ovf_rel_gate_hold", 64'(bus.voice_gate), 64'hF);
    cyc(1);
    check_eq("ovf_gate_fall", 64'(bus.voice_gate), 64'hE);
    check_eq("ovf_busy", 64'(bus.voice_busy), 64'hF);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check_eq("ovf_tail_busy", 64'(bus.voice_busy), 64'hF);
      check_eq("ovf_tail_starved", 64'(bus.starved), 64'd1);
    end
    cyc(1);
    check_eq("ovf_expired", 64'(bus.voice_busy), 64'hE);
    check_eq("ovf_expired_starved", 64'(bus.starved), 64'd1);
    check_eq("ovf_expired_nostart", 64'(bus.voice_start), 64'h0);
    cyc(1);
    check_eq("ovf_regrant_gate", 64'(bus.voice_gate), 64'hF);
    check_eq("ovf_regrant_start", 64'(bus.voice_start), 64'h1);
    check_eq("ovf_regrant_note", 64'(bus.voice_note[2:0]), 64'd2);
    check_eq("ovf_starved_drop", 64'(bus.starved), 64'd0);

    // 5. retrigger of key A during its tail
    bus.sw = 8'h00;
    cyc(20);
    check_eq("t5_all_idle", 64'(bus.voice_busy), 64'h0);
    bus.sw = 8'h26;
    cyc(9);
    check_eq("t5_notes", 64'(bus.voice_note), 64'hF51);
    check_eq("t5_gate", 64'(bus.voice_gate), 64'h7);
    bus.sw = 8'h06;
    cyc(6);
    check_eq("t5_db_fall", 64'(bus.db_keys), 64'h06);
    cyc(1);
    check_eq("t5_gate_fall", 64'(bus.voice_gate), 64'h3);
    check_eq("t5_busy", 64'(bus.voice_busy), 64'h7);
    bus.sw = 8'h26;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check_eq("t5_tail_busy", 64'(bus.voice_busy), 64'h7);
      check_eq("t5_tail_gate", 64'(bus.voice_gate), 64'h3);
      check_eq("t5_tail_start", 64'(bus.voice_start), 64'h0);
    end
    cyc(1);
    check_eq("t5_retrig_gate", 64'(bus.voice_gate), 64'h7);
    check_eq("t5_retrig_start", 64'(bus.voice_start), 64'h4);
    check_eq("t5_retrig_notes", 64'(bus.voice_note), 64'hF51);
    cyc(1);
    check_eq("t5_start_end", 64'(bus.voice_start), 64'h0);
    check_eq("t5_no_other", 64'(bus.voice_busy), 64'h7);

    // 6. async reset with three ACTIVE and one in RELEASE
    bus.sw = 8'hA6;
    cyc(7);
    check_eq("t6_gate_full", 64'(bus.voice_gate), 64'hF);
    check_eq("t6_start_v3", 64'(bus.voice_start), 64'h8);
    bus.sw = 8'hA4;
    cyc(7);
    check_eq("t6_gate_rel", 64'(bus.voice_gate), 64'hE);
    check_eq("t6_busy_rel", 64'(bus.voice_busy), 64'hF);
    cyc(2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_async_clear", all_out(), 64'd0);
    cyc(2);
    check_eq("t6_reset_hold", all_out(), 64'd0);
    rst_n = 1'b1;
    cyc(6);
    check_eq("t6_db_again", 64'(bus.db_keys), 64'hA4);
    check_eq("t6_gate_none", 64'(bus.voice_gate), 64'h0);
    cyc(3);
    check_eq("t6_gate_again", 64'(bus.voice_gate), 64'h7);
    check_eq("t6_notes_again", 64'(bus.voice_note), 64'h1EA);
    check_eq("t6_start_last", 64'(bus.voice_start), 64'h4);
    check_eq("t6_starved", 64'(bus.starved), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
